// File: rtl/rd_ctrl.sv
// Cache read-side controller: tag lookup, miss allocation and line fetch,
// same-line arbitration with the writer, line-memory read and ready/valid response.
module rd_ctrl #(
    parameter int addr_width = 32,
    parameter int list_depth = 4,
    parameter int data_width = 32,
    parameter int list_width = 32,
    localparam int TW = $clog2(list_depth),
    localparam int OW = $clog2(list_width)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [addr_width-1:0] rd_addr,
    output logic                  rd_rvalid,
    input  logic                  rd_rready,
    output logic [data_width-1:0] rd_rdata,
    output logic                  acc_req,
    output logic [1:0]            acc_cmd,
    output logic [TW-1:0]         acc_tag,
    output logic [addr_width-1:0] acc_index,
    input  logic [2:0]            acc_status,
    input  logic [TW-1:0]         return_tag,
    output logic [2:0]            proc_status_w,
    output logic [addr_width-1:0] proc_addr_w,
    input  logic [2:0]            proc_status_r,
    input  logic [addr_width-1:0] proc_addr_r,
    output logic                  fetch_req,
    output logic [1:0]            fetch_cmd,
    output logic [TW-1:0]         fetch_tag,
    output logic [addr_width-1:0] fetch_addr,
    input  logic                  fetch_gnt,
    input  logic                  fetch_done,
    output logic                  mem_ren,
    output logic [TW+OW-1:0]      mem_raddr,
    input  logic                  mem_rready,
    input  logic [data_width-1:0] mem_rdata
);

    typedef enum logic [3:0] {
        IDLE, LOOKUP, CHK_CONF, WAIT_CONF, ALLOC,
        FETCH_REQ, WAIT_FETCH, MEM_RD, MEM_WAIT, RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [addr_width-1:0]   addr_q, addr_d;
    logic [TW-1:0]           tag_q, tag_d;
    logic [1:0]              fcmd_q, fcmd_d;
    logic                    fill_q, fill_d;
    logic [data_width-1:0]   rdata_q, rdata_d;

    logic                    accept;
    logic                    hit;
    logic [addr_width-1:0]   cur_addr;
    logic [addr_width-1:0]   la;
    logic [OW-1:0]           off;

    // The request address is live in the accept cycle, registered afterwards.
    assign accept   = rd_valid && (state_q == IDLE);
    assign cur_addr = accept ? rd_addr : addr_q;
    assign la       = {cur_addr[addr_width-1:OW], {OW{1'b0}}};
    assign off      = cur_addr[OW-1:0];
    assign hit      = (acc_status == 3'b001);

    assign rd_ready    = (state_q == IDLE);
    assign rd_rdata    = rdata_q;
    assign acc_index   = la;
    assign proc_addr_w = la;
    assign fetch_addr  = la;
    assign fetch_cmd   = fcmd_q;
    assign fetch_tag   = tag_q;
    assign mem_raddr   = {tag_q, off};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            tag_q   <= '0;
            fcmd_q  <= '0;
            fill_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            fcmd_q  <= fcmd_d;
            fill_q  <= fill_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        tag_d         = tag_q;
        fcmd_d        = fcmd_q;
        fill_d        = fill_q;
        rdata_d       = rdata_q;
        acc_req       = 1'b0;
        acc_cmd       = 2'b00;
        acc_tag       = '0;
        proc_status_w = 3'b000;
        fetch_req     = 1'b0;
        mem_ren       = 1'b0;
        rd_rvalid     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_req = 1'b1;
                    addr_d  = rd_addr;
                    tag_d   = return_tag;
                    state_d = hit ? MEM_RD : CHK_CONF;
                end
            end
            LOOKUP: begin
                acc_req = 1'b1;
                tag_d   = return_tag;
                state_d = hit ? MEM_RD : CHK_CONF;
            end
            CHK_CONF: begin
                proc_status_w = 3'b001;
                // Only a writer actively filling the same line blocks us.
                if (proc_status_r == 3'b010 && proc_addr_r == la)
                    state_d = WAIT_CONF;
                else
                    state_d = ALLOC;
            end
            WAIT_CONF: begin
                if (proc_status_r == 3'b011)
                    state_d = LOOKUP;
            end
            ALLOC: begin
                proc_status_w = 3'b010;
                acc_req       = 1'b1;
                acc_cmd       = 2'b10;
                tag_d         = return_tag;
                fcmd_d        = acc_status[1:0];
                state_d       = FETCH_REQ;
            end
            FETCH_REQ: begin
                proc_status_w = 3'b010;
                fetch_req     = 1'b1;
                if (fetch_gnt)
                    state_d = WAIT_FETCH;
            end
            WAIT_FETCH: begin
                proc_status_w = 3'b010;
                if (fetch_done) begin
                    fill_d  = 1'b1;
                    state_d = MEM_RD;
                end
            end
            MEM_RD: begin
                mem_ren = 1'b1;
                if (fill_q)
                    proc_status_w = mem_rready ? 3'b011 : 3'b010;
                if (mem_rready) begin
                    // Fill completion is reported to the tag list with the read handshake.
                    if (fill_q) begin
                        acc_req = 1'b1;
                        acc_cmd = 2'b11;
                        acc_tag = tag_q;
                    end
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                rdata_d = mem_rdata;
                state_d = RESP;
            end
            RESP: begin
                rd_rvalid = 1'b1;
                if (rd_rready) begin
                    fill_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
